// File: rtl/multiplicador_seq_pkg.sv
// Shared RV32M multiply definitions: op encodings (funct3[1:0]), FSM states and
// helpers deciding which operands are sign-interpreted for a given op.
package rv_mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic a_is_signed(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  function automatic logic b_is_signed(input op_e op);
    return (op == OP_MULH);
  endfunction

endpackage

// File: rtl/multiplicador_seq_if.sv
// Start/done request bus between execute-stage control and the sequential multiplier.
// Requester drives start/op/a/b; the multiplier returns busy/done/result.
interface multiplicador_seq_if #(
  parameter int SIZE = 32
);
  logic            start;
  logic [1:0]      op;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/multiplicador_seq_adder.sv
// Ripple-carry adder, combinational, W bits with carry in/out.
// Zero latency; no flow control.
module multiplicador_seq_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = x[i] ^ y[i] ^ carry;
      carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/multiplicador_seq.sv
// Shift-and-add RV32M multiplier on unsigned magnitudes with a final sign fix-up step.
// done comes SIZE+1 edges after the accepting edge; start is ignored outside IDLE.
module multiplicador_seq
  import rv_mul_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  multiplicador_seq_if.slave  bus
);

  localparam int W2 = 2 * SIZE;
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  state_e          state, state_nxt;
  op_e             op_q;
  logic            neg_q;
  logic [SIZE-1:0] mcand_q;
  logic [W2-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic [SIZE-1:0] result_q;

  op_e             op_in;
  logic            a_neg, b_neg;
  logic [SIZE-1:0] a_abs, b_abs;
  logic [SIZE-1:0] add_y, add_sum;
  logic            add_cout;
  logic [W2-1:0]   acc_fin;

  // Magnitudes stay unsigned SIZE-bit, so -2^(SIZE-1) maps to itself without overflow.
  assign op_in = op_e'(bus.op);
  assign a_neg = a_is_signed(op_in) & bus.a[SIZE-1];
  assign b_neg = b_is_signed(op_in) & bus.b[SIZE-1];
  assign a_abs = a_neg ? (~bus.a + SIZE'(1)) : bus.a;
  assign b_abs = b_neg ? (~bus.b + SIZE'(1)) : bus.b;

  // Masking the multiplicand makes the no-add case a plain shift with carry 0.
  assign add_y = mcand_q & {SIZE{acc_q[0]}};

  multiplicador_seq_adder #(.W(SIZE)) u_adder (
    .x    (acc_q[W2-1:SIZE]),
    .y    (add_y),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign acc_fin = neg_q ? (~acc_q + W2'(1)) : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_CALC;
      ST_CALC: if (cnt_q == '0) state_nxt = ST_SIGN;
      ST_SIGN: state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q    <= op_in;
            neg_q   <= a_neg ^ b_neg;
            mcand_q <= a_abs;
            acc_q   <= {{SIZE{1'b0}}, b_abs};
            cnt_q   <= CW'(SIZE - 1);
          end
        end
        ST_CALC: begin
          acc_q <= {add_cout, add_sum, acc_q[SIZE-1:1]};
          cnt_q <= cnt_q - CW'(1);
        end
        ST_SIGN: begin
          acc_q    <= acc_fin;
          result_q <= (op_q == OP_MUL) ? acc_fin[SIZE-1:0] : acc_fin[W2-1:SIZE];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == ST_CALC) || (state == ST_SIGN);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Randomized and directed checks of multiplicador_seq against a 64-bit arithmetic reference.
module tb_multiplicador_seq;

  localparam int SIZE = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  multiplicador_seq_if #(.SIZE(SIZE)) bus ();

  multiplicador_seq #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Full product in 64-bit modular arithmetic; every RV32M product fits exactly.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Called at a negedge with the DUT idle. Cycle 0 is the cycle start is presented in.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    int busy_cyc;
    logic [31:0] res;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom_range(0, 3));
    cyc = 0; busy_cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cyc++;
    end while (!bus.done && cyc < 100);
    res = bus.result;
    chk({tag, " latency"}, 64'(cyc), 64'(SIZE + 2));
    chk({tag, " busy_len"}, 64'(busy_cyc), 64'(SIZE + 1));
    chk({tag, " result"}, 64'(res), 64'(exp));
    @(negedge clk);
    chk({tag, " done_width"}, 64'(bus.done), 64'(0));
    chk({tag, " result_hold"}, 64'(bus.result), 64'(res));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10] = '{
    '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A},
    '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1},
    '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
    '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
    '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001},
    '{2'b01, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000},
    '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000}
  };

  logic [31:0] corner[4] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF};

  initial begin
    int dones;
    int cyc;
    int gap;
    logic [31:0] a1, b1;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    #2;
    chk("reset busy", 64'(bus.busy), 64'(0));
    chk("reset done", 64'(bus.done), 64'(0));
    chk("reset result", 64'(bus.result), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op($sformatf("dir%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 16; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      run_op($sformatf("rnd%0d", i), op, a, b, ref_mul(op, a, b));
    end

    // Abort mid-CALC: outputs clear at once, and the aborted op never completes.
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd1000; bus.b = 32'd1000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(bus.busy), 64'(0));
    chk("abort done", 64'(bus.done), 64'(0));
    chk("abort result", 64'(bus.result), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort no_done", 64'(dones), 64'(0));
    run_op("post_abort", 2'b00, 32'd3, 32'd4, 32'd12);

    // start held high with operands churning while busy.
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678;
    @(posedge clk); #1;
    cyc = 0; dones = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!bus.done) begin bus.a = $urandom; bus.b = $urandom; end
    end while (!bus.done && cyc < 100);
    chk("held latency", 64'(cyc), 64'(SIZE + 2));
    chk("held result", 64'(bus.result), 64'(ref_mul(2'b11, 32'hDEAD_BEEF, 32'h1234_5678)));
    a1 = $urandom; b1 = $urandom;
    bus.a = a1; bus.b = b1;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) chk("held done_width", 64'(bus.done), 64'(0));
      if (gap == 2) begin bus.a = $urandom; bus.b = $urandom; end
    end while (!bus.done && gap < 100);
    chk("held throughput", 64'(gap), 64'(SIZE + 3));
    chk("held second_result", 64'(bus.result), 64'(ref_mul(2'b11, a1, b1)));
    bus.start = 1'b0;
    @(negedge clk);
    chk("held done_width2", 64'(bus.done), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
